// File: rtl/riscv_insn_encode_pkg.sv
// Shared RV32 encoding types: format enum, opcode constants and pure field-packing helpers
// used by the encoder datapath.
package riscv_insn_types;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_BAD6 = 3'd6,
    FMT_BAD7 = 3'd7
  } insn_fmt_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  typedef struct packed {
    logic [31:0] insn;
    logic        err;
  } enc_res_t;

  function automatic logic [31:0] pack_R(input logic [6:0] funct7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] funct3,
                                         input logic [4:0] rd, input logic [6:0] opcode);
    return {funct7, rs2, rs1, funct3, rd, opcode};
  endfunction

  function automatic logic [31:0] pack_I(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] funct3, input logic [4:0] rd,
                                         input logic [6:0] opcode);
    return {imm[11:0], rs1, funct3, rd, opcode};
  endfunction

  function automatic logic [31:0] pack_S(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] funct3,
                                         input logic [6:0] opcode);
    return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
  endfunction

  function automatic logic [31:0] pack_B(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] funct3,
                                         input logic [6:0] opcode);
    return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
  endfunction

  function automatic logic [31:0] pack_U(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opcode);
    return {imm[31:12], rd, opcode};
  endfunction

  function automatic logic [31:0] pack_J(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opcode);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
  endfunction

  // True when the immediate is representable (sign-extension intact, alignment met) for fmt.
  function automatic logic imm_fits(input insn_fmt_e fmt, input logic [31:0] imm);
    logic fits;
    case (fmt)
      FMT_I, FMT_S: fits = (&imm[31:11]) | ~(|imm[31:11]);
      FMT_B:        fits = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      FMT_J:        fits = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      FMT_U:        fits = ~(|imm[11:0]);
      default:      fits = 1'b1;
    endcase
    return fits;
  endfunction

endpackage

// File: rtl/riscv_insn_encode_pack.sv
// Combinational field packer: selects the format layout and flags range/format errors.
module riscv_insn_pack #(
  parameter int CHECK_RANGE = 1
) (
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] insn_o,
  output logic        err_o
);
  import riscv_insn_types::*;

  insn_fmt_e fmt_s;
  logic      range_err_s;

  assign fmt_s       = insn_fmt_e'(fmt_i);
  assign range_err_s = (CHECK_RANGE != 0) && !imm_fits(fmt_s, imm_i);

  // Format mux; truncated fields are still packed when the immediate is out of range.
  always_comb begin
    insn_o = 32'h0000_0000;
    err_o  = range_err_s;
    case (fmt_s)
      FMT_R:   insn_o = pack_R(funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i);
      FMT_I:   insn_o = pack_I(imm_i, rs1_i, funct3_i, rd_i, opcode_i);
      FMT_S:   insn_o = pack_S(imm_i, rs2_i, rs1_i, funct3_i, opcode_i);
      FMT_B:   insn_o = pack_B(imm_i, rs2_i, rs1_i, funct3_i, opcode_i);
      FMT_U:   insn_o = pack_U(imm_i, rd_i, opcode_i);
      FMT_J:   insn_o = pack_J(imm_i, rd_i, opcode_i);
      default: begin
        insn_o = 32'h0000_0000;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/riscv_insn_encode.sv
// RV32 instruction encoder: valid/ready intake, 2-entry output FIFO and wrapping
// accept/error counters around the combinational packer.
module riscv_insn_encode #(
  parameter int CHECK_RANGE = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_insn,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  import riscv_insn_types::*;

  logic [31:0]      pack_insn_s;
  logic             pack_err_s;
  enc_res_t         fifo_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             push_s, pop_s;

  riscv_insn_pack #(.CHECK_RANGE(CHECK_RANGE)) u_pack (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .insn_o   (pack_insn_s),
    .err_o    (pack_err_s)
  );

  // in_ready is a flop, so a push can only happen while a slot is known free.
  assign push_s = in_valid & in_ready_q;
  assign pop_s  = (cnt_q != 2'd0) & out_ready;

  // Next-state for FIFO pointers, occupancy, registered ready and counters.
  always_comb begin
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (push_s) begin
      wr_ptr_d  = ~wr_ptr_q;
      enc_cnt_d = enc_cnt_q + CNT_W'(1);
      if (pack_err_s) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      wr_ptr_d  = wr_ptr_q;
      enc_cnt_d = enc_cnt_q;
      err_cnt_d = err_cnt_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    in_ready_d = (cnt_d < 2'd2);
  end

  // State registers and FIFO storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= {pack_insn_s, pack_err_s};
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      enc_cnt_q  <= enc_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_insn  = fifo_q[rd_ptr_q].insn;
  assign out_err   = fifo_q[rd_ptr_q].err;
  assign enc_cnt   = enc_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_riscv_insn_encode.sv
// Scoreboard bench: two encoder instances (range checking on / off, 16- and 4-bit counters)
// share stimulus; a negedge monitor compares each against a field-arithmetic reference model.
module tb_riscv_insn_encode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  logic        a_in_ready, a_out_valid, a_out_err;
  logic [31:0] a_out_insn;
  logic [15:0] a_enc_cnt, a_err_cnt;
  logic        b_in_ready, b_out_valid, b_out_err;
  logic [31:0] b_out_insn;
  logic [3:0]  b_enc_cnt, b_err_cnt;

  always #5 clk = ~clk;

  riscv_insn_encode #(.CHECK_RANGE(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_insn(a_out_insn),
    .out_err(a_out_err), .enc_cnt(a_enc_cnt), .err_cnt(a_err_cnt)
  );

  riscv_insn_encode #(.CHECK_RANGE(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_insn(b_out_insn),
    .out_err(b_out_err), .enc_cnt(b_enc_cnt), .err_cnt(b_err_cnt)
  );

  typedef struct {
    logic [31:0] insn;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] lit_insn;
    logic        lit_err_a, lit_err_b;
  } dir_t;

  exp_t qa[$], qb[$];
  exp_t pend_a, pend_b;
  int   n_chk = 0, n_fail = 0;
  int   enc_a = 0, err_a = 0, enc_b = 0, err_b = 0;
  bit   fresh_a = 1'b1, fresh_b = 1'b1;
  bit   mon_en = 1'b0, rand_or = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Bits [lo +: w] of v placed at bit position pos.
  function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int w, input int pos);
    return ((v >> lo) & ((32'd1 << w) - 32'd1)) << pos;
  endfunction

  function automatic exp_t model(input bit range_on, input logic [2:0] fmt, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    exp_t e;
    int   si;
    bit   bad;
    logic [31:0] base;
    si   = int'(imm);
    bad  = 1'b0;
    base = fld(32'(op), 0, 7, 0);
    case (fmt)
      3'd0: e.insn = base | fld(32'(f7), 0, 7, 25) | fld(32'(rs2), 0, 5, 20) | fld(32'(rs1), 0, 5, 15)
                          | fld(32'(f3), 0, 3, 12) | fld(32'(rd), 0, 5, 7);
      3'd1: begin
        e.insn = base | fld(imm, 0, 12, 20) | fld(32'(rs1), 0, 5, 15) | fld(32'(f3), 0, 3, 12)
                      | fld(32'(rd), 0, 5, 7);
        bad = (si < -2048) || (si > 2047);
      end
      3'd2: begin
        e.insn = base | fld(imm, 5, 7, 25) | fld(32'(rs2), 0, 5, 20) | fld(32'(rs1), 0, 5, 15)
                      | fld(32'(f3), 0, 3, 12) | fld(imm, 0, 5, 7);
        bad = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        e.insn = base | fld(imm, 12, 1, 31) | fld(imm, 5, 6, 25) | fld(32'(rs2), 0, 5, 20)
                      | fld(32'(rs1), 0, 5, 15) | fld(32'(f3), 0, 3, 12) | fld(imm, 1, 4, 8)
                      | fld(imm, 11, 1, 7);
        bad = (si < -4096) || (si > 4095) || (si % 2 != 0);
      end
      3'd4: begin
        e.insn = base | fld(imm, 12, 20, 12) | fld(32'(rd), 0, 5, 7);
        bad = (si % 4096) != 0;
      end
      3'd5: begin
        e.insn = base | fld(imm, 20, 1, 31) | fld(imm, 1, 10, 21) | fld(imm, 11, 1, 20)
                      | fld(imm, 12, 8, 12) | fld(32'(rd), 0, 5, 7);
        bad = (si < -1048576) || (si > 1048575) || (si % 2 != 0);
      end
      default: begin
        e.insn = 32'h0;
        bad    = 1'b1;
        range_on = 1'b1;
      end
    endcase
    e.err = range_on && bad;
    return e;
  endfunction

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    pend_a = model(1'b1, fmt, op, rd, rs1, rs2, f3, f7, imm);
    pend_b = model(1'b0, fmt, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
  endtask

  // Hold the request until accepted, bounded; leaves time at posedge+1.
  task automatic wait_acc();
    int  k;
    bit  acc;
    k = 0;
    acc = 1'b0;
    while (!acc && k < 100) begin
      @(negedge clk);
      acc = a_in_ready;
      k++;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles at %0t", $time);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_dir(input dir_t d);
    drive(d.fmt, d.op, d.rd, d.rs1, d.rs2, d.f3, d.f7, d.imm);
    pend_a.insn = d.lit_insn; pend_a.err = d.lit_err_a;
    pend_b.insn = d.lit_insn; pend_b.err = d.lit_err_b;
    wait_acc();
  endtask

  task automatic send_rand();
    logic [31:0] bnd [12];
    logic [31:0] imm;
    bnd = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF, 32'd4094, 32'hFFFF_F000,
            32'd4096, 32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000, 32'h1234_5000, 32'h0000_1001};
    case ($urandom_range(0, 4))
      0:       imm = $urandom;
      1:       imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      2:       imm = bnd[$urandom_range(0, 11)];
      3:       imm = $urandom & 32'hFFFF_F000;
      default: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
    endcase
    drive(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          3'($urandom), 7'($urandom), imm);
    wait_acc();
  endtask

  task automatic idle_junk(input int n);
    for (int i = 0; i < n; i++) begin
      in_fmt = 3'($urandom); in_opcode = 7'($urandom); in_rd = 5'($urandom); in_imm = $urandom;
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: checks DUT state against the model, then applies this cycle's push/pop.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_in_ready", 32'(a_in_ready), 32'(qa.size() < 2));
      chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
      chk("a_enc_cnt", 32'(a_enc_cnt), 32'(enc_a & 32'hFFFF));
      chk("a_err_cnt", 32'(a_err_cnt), 32'(err_a & 32'hFFFF));
      chk("b_in_ready", 32'(b_in_ready), 32'(qb.size() < 2));
      chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
      chk("b_enc_cnt", 32'(b_enc_cnt), 32'(enc_b & 32'hF));
      chk("b_err_cnt", 32'(b_err_cnt), 32'(err_b & 32'hF));
      if (qa.size() != 0) begin
        chk("a_out_insn", a_out_insn, qa[0].insn);
        chk("a_out_err", 32'(a_out_err), 32'(qa[0].err));
      end else if (fresh_a) begin
        chk("a_reset_insn", a_out_insn, 32'h0);
        chk("a_reset_err", 32'(a_out_err), 32'h0);
      end
      if (qb.size() != 0) begin
        chk("b_out_insn", b_out_insn, qb[0].insn);
        chk("b_out_err", 32'(b_out_err), 32'(qb[0].err));
      end else if (fresh_b) begin
        chk("b_reset_insn", b_out_insn, 32'h0);
      end
      if (rst) begin
        qa.delete(); qb.delete();
        enc_a = 0; err_a = 0; enc_b = 0; err_b = 0;
        fresh_a = 1'b1; fresh_b = 1'b1;
      end else begin
        if (a_out_valid && out_ready && qa.size() != 0) void'(qa.pop_front());
        if (b_out_valid && out_ready && qb.size() != 0) void'(qb.pop_front());
        if (in_valid && a_in_ready) begin
          qa.push_back(pend_a); enc_a++; if (pend_a.err) err_a++; fresh_a = 1'b0;
        end
        if (in_valid && b_in_ready) begin
          qb.push_back(pend_b); enc_b++; if (pend_b.err) err_b++; fresh_b = 1'b0;
        end
      end
    end
  end

  // Random consumer backpressure while enabled.
  always @(posedge clk) begin
    if (rand_or) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dir_t dirs [8];
    int   k;
    dirs[0] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h0020_81B3, 1'b0, 1'b0};
    dirs[1] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b0};
    dirs[2] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h8, 32'h0020_A423, 1'b0, 1'b0};
    dirs[3] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 1'b0};
    dirs[4] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h0010_00EF, 1'b0, 1'b0};
    dirs[5] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h3, 32'h0000_0163, 1'b1, 1'b0};
    dirs[6] = '{3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h8000_0013, 1'b1, 1'b0};
    dirs[7] = '{3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h0, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send_dir(dirs[i]);
      idle_junk(1);
    end
    idle_junk(3);
    chk("err_cnt_after_directed", 32'(a_err_cnt), 32'd3);

    // Backpressure: two fill the FIFO, the third waits until the consumer drains.
    out_ready = 1'b0;
    send_dir(dirs[0]);
    send_dir(dirs[1]);
    drive(dirs[2].fmt, dirs[2].op, dirs[2].rd, dirs[2].rs1, dirs[2].rs2, dirs[2].f3, dirs[2].f7, dirs[2].imm);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_acc();
    idle_junk(4);

    rand_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send_rand();
      idle_junk($urandom_range(0, 2));
    end
    rand_or = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    idle_junk(4);

    // Reset with the FIFO full discards both entries.
    send_rand();
    send_rand();
    idle_junk(2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    idle_junk(2);
    for (int i = 0; i < 20; i++) send_rand();

    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drained_a", 32'(qa.size()), 32'd0);
    chk("drained_b", 32'(qb.size()), 32'd0);
    idle_junk(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_insn_encode.md
Name: riscv_insn_encode

Overview:
Pipelined RISC-V RV32 instruction encoder. It is the inverse of the existing type decoder: it packs opcode, register, funct and immediate fields into a 32-bit instruction word for formats R/I/S/B/U/J. Used by the self-test instruction generator and the debug-module instruction injector. It has a valid/ready input, a 2-entry output skid buffer, immediate range checking, and wrapping statistics counters.

Parameters:
CHECK_RANGE, 1, 1 = flag out-of-range or misaligned immediates on out_err; 0 = flag only illegal formats
CNT_W, 16, width of the encoded-instruction and error counters

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept; registered
in_fmt  input  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 illegal
in_opcode  input  7  opcode[6:0]
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R only)
in_imm  input  32  sign-extended byte-offset immediate; U takes imm[31:12] in place
out_valid  output  1  buffered result valid
out_ready  input  1  consumer accepts
out_insn  output  32  encoded instruction
out_err  output  1  range, alignment or format error for out_insn
enc_cnt  output  CNT_W  accepted requests, wraps
err_cnt  output  CNT_W  accepted requests with error, wraps

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - buffer emptied; out_valid=0; out_insn=0; out_err=0; in_ready=1; enc_cnt=0; err_cnt=0.
  - Reset mid-operation discards buffered entries without emitting them.
- Accept: in_valid && in_ready at posedge. Pop: out_valid && out_ready at posedge.
- Latency: an accepted request is visible on out_insn/out_valid at the next cycle at the earliest.
- Buffer: 2-entry FIFO; order preserved.
  - out_valid = (count != 0); out_insn/out_err show the head entry.
  - in_ready registered: next in_ready = (next count < 2). No combinational out_ready -> in_ready path.
  - count 1, simultaneous push and pop: count stays 1, new entry becomes head next cycle.
  - count 2: no push possible; a pop leaves count 1 and in_ready=1 next cycle.
  - count 0, push: count 1 (no bypass).
- Packing (bit fields, MSB first):
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
  - Fields not used by a format are ignored.
- Error rules (CHECK_RANGE=1):
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - R: never errors.
  - On a range/alignment error the word is still packed from truncated fields and out_err=1.
- Illegal fmt (6/7): out_insn=32'h0, out_err=1, regardless of CHECK_RANGE.
- Counters:
  - enc_cnt increments on each accept; err_cnt increments on each accept whose computed err=1.
  - Both wrap at 2^CNT_W-1 -> 0.
- Input fields are sampled only on accept. Input values while in_valid=0 have no effect.

Decomposition:
- Package riscv_insn_types gains:
  - insn_fmt_e enum (3-bit)
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR)
  - pure functions pack_R/I/S/B/U/J and imm_fits(fmt, imm)
- One combinational sub-module, riscv_insn_pack: fields+fmt -> {insn, err}. The top module holds the FIFO, handshake and counters.

Test Plan:
- R: fmt=0, op=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> out_insn=0x002081B3, err=0, one cycle after accept.
- I/S: addi x1,x0,-1 (imm=0xFFFFFFFF) -> 0xFFF00093; sw x2,8(x1) (op 0x23, f3=2) -> 0x0020A423; both err=0.
- B/J: beq x0,x0,-4 -> 0xFE000EE3; jal x1,+2048 (op 0x6F, imm 0x800) -> 0x001000EF.
- Errors:
  - B imm=3 -> err=1; I imm=0x800 -> err=1; fmt=7 -> insn=0, err=1; err_cnt=3.
  - Rerun with CHECK_RANGE=0: only fmt=7 errors.
- Backpressure:
  - Sequence: out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepts.
  - Then set out_ready=1 -> entries drain in push order, third accepted once in_ready=1.
  - enc_cnt=3.
- Reset with 2 buffered -> next cycle out_valid=0, in_ready=1, counters 0; preload enc_cnt to 0xFFFF then accept -> 0.
